// File: rtl/uart_rx_word.sv
// 8N1 serial receiver that assembles groups of four bytes (first byte = MSB) into 32-bit words.
// A partial word is dropped on a framing error or after an idle gap timeout.
module uart_rx_word #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 43400
) (
    input  logic        clk_50m,
    input  logic        sw_rst_n,
    input  logic        uart_rx_i,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    output logic        frame_err_o,
    output logic        timeout_o,
    output logic        busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t          state, state_nx;
    logic            rx_meta, rx_s;
    logic [CW-1:0]   bit_cnt, bit_cnt_nx;
    logic [2:0]      bit_idx, bit_idx_nx;
    logic [7:0]      shift, shift_nx;
    logic            byte_stb, ferr_stb;
    logic [1:0]      byte_cnt;
    logic [23:0]     partial;
    logic [TW-1:0]   gap_cnt;

    // Sync flops reset high so reset never looks like a start bit.
    always_ff @(posedge clk_50m or negedge sw_rst_n) begin
        if (!sw_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking here so every register samples pre-edge values, like real flops.
            rx_meta <= uart_rx_i;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_50m or negedge sw_rst_n) begin
        if (!sw_rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, otherwise missing branches infer latches.
        state_nx   = state;
        bit_cnt_nx = bit_cnt + 1'b1;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        byte_stb   = 1'b0;
        ferr_stb   = 1'b0;
        unique case (state)
            IDLE: begin
                bit_cnt_nx = '0;
                if (!rx_s) state_nx = START;
            end
            START: begin
                if (bit_cnt == HALF_LAST) begin
                    bit_cnt_nx = '0;
                    bit_idx_nx = '0;
                    state_nx   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_nx = '0;
                    shift_nx   = {rx_s, shift[7:1]};
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nx = STOP;
                end
            end
            STOP: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_nx = '0;
                    if (rx_s) begin
                        byte_stb = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        ferr_stb = 1'b1;
                        state_nx = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                bit_cnt_nx = '0;
                if (rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Word assembler and inter-byte gap timer; a byte strobe always wins over timer expiry.
    always_ff @(posedge clk_50m or negedge sw_rst_n) begin
        if (!sw_rst_n) begin
            byte_o       <= '0;
            byte_valid_o <= 1'b0;
            word_o       <= '0;
            word_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            timeout_o    <= 1'b0;
            byte_cnt     <= '0;
            partial      <= '0;
            gap_cnt      <= '0;
        end else begin
            byte_valid_o <= byte_stb;
            frame_err_o  <= ferr_stb;
            word_valid_o <= 1'b0;
            timeout_o    <= 1'b0;
            if (byte_stb) begin
                byte_o  <= shift;
                gap_cnt <= '0;
                if (byte_cnt == 2'd3) begin
                    word_o       <= {partial, shift};
                    word_valid_o <= 1'b1;
                    byte_cnt     <= '0;
                end else begin
                    partial  <= {partial[15:0], shift};
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end else if (ferr_stb) begin
                byte_cnt <= '0;
                gap_cnt  <= '0;
            end else if (byte_cnt == 2'd0) begin
                gap_cnt <= '0;
            end else if (state == IDLE) begin
                if (gap_cnt == GAP_LAST) begin
                    byte_cnt  <= '0;
                    timeout_o <= 1'b1;
                    gap_cnt   <= '0;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
            end
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: doc/uart_rx_word.md
# uart_rx_word

Asynchronous serial receiver front end for the PicoBlaze UART/7-segment design. Synchronises the `uart_rx_i` pin, recovers 8N1 bytes at a fixed baud rate, and assembles each group of four bytes (first byte = MSB) into a 32-bit word for the downstream CRC/command logic. A partial word is discarded after an inter-byte gap timeout or a framing error, so the host can always resynchronise.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per bit (50 MHz / 115200 baud).
- `TIMEOUT_CLKS`, 43400, idle clocks after a byte before a partial word is dropped (100 bit times).
- `clk_50m`  in  1  system clock. One clock domain only.
- `sw_rst_n`  in  1  reset. Asynchronous, active-low.
- `uart_rx_i`  in  1  serial line, idle high, asynchronous to `clk_50m`.
- `byte_o`  out  8  last received byte.
- `byte_valid_o`  out  1  one-cycle pulse, `byte_o` newly valid.
- `word_o`  out  32  last assembled word.
- `word_valid_o`  out  1  one-cycle pulse, `word_o` newly valid.
- `frame_err_o`  out  1  one-cycle pulse, stop bit sampled low.
- `timeout_o`  out  1  one-cycle pulse, partial word dropped by gap timeout.
- `busy_o`  out  1  receiver FSM not in IDLE.

## Operation
- Input sync: 2-flop synchroniser, both flops reset to 1. The FSM uses only the synchronised bit `rx_s`.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. A single bit counter `bit_cnt` is sized with `$clog2(CLKS_PER_BIT)`, and a 3-bit `bit_idx` tracks the data bit.
- IDLE: when `rx_s`==0, go to START and clear `bit_cnt`.
- START: when `bit_cnt` reaches `CLKS_PER_BIT/2-1` (mid start bit), sample `rx_s`.
  - If 1, it is a glitch: return to IDLE with no outputs.
  - If 0, go to DATA with `bit_cnt` and `bit_idx` cleared.
- DATA: every `CLKS_PER_BIT` clocks, sample `rx_s` into the shift register, LSB first. After `bit_idx`==7 has been sampled, go to STOP.
- STOP: after `CLKS_PER_BIT` clocks, sample `rx_s`.
  - If 1: load `byte_o`, pulse `byte_valid_o`, go to IDLE.
  - If 0: pulse `frame_err_o`, leave `byte_o` unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. A line held low (break) never produces bytes.
- Assembler: 2-bit `byte_cnt` and 24-bit `partial`.
  - On each byte strobe with `byte_cnt`<3: `partial` <= {`partial`[15:0], byte}, and `byte_cnt` increments.
  - On the strobe with `byte_cnt`==3: `word_o` <= {`partial`, byte}, pulse `word_valid_o`, and `byte_cnt` <= 0.
- Gap timer: counts while `byte_cnt`!=0 and the FSM is in IDLE. It clears on every byte strobe.
  - At `TIMEOUT_CLKS`: `byte_cnt` <= 0, pulse `timeout_o`, clear the timer.
  - The timer also stays clear while `byte_cnt`==0.
- Framing error: also forces `byte_cnt` <= 0. `timeout_o` does not fire for this event.
- Simultaneous events: a byte strobe and a timer expiry cannot coincide, because the timer is cleared by the strobe and the strobe has priority.

## Timing
- Reset values: `byte_o`=0, `word_o`=0, all pulses 0, `busy_o`=0, FSM in IDLE, counters 0, sync flops 1.
- Reset asserted mid-frame aborts the frame immediately. Nothing is emitted and the partial word is lost.
- Latency, with t0 = first clock on which `rx_s`==0 (2–3 clocks after the pin edge):
  - Start check at t0+`CLKS_PER_BIT/2`.
  - Data bit i sampled at t0+`CLKS_PER_BIT/2`+(i+1)·`CLKS_PER_BIT`.
  - Stop sampled at t0+`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT`.
- `byte_valid_o` and `frame_err_o` assert on the clock after the stop sample, for exactly 1 cycle.
- `word_valid_o` asserts in the same cycle as the 4th `byte_valid_o`, and `word_o` is stable from that cycle.
- `word_o` and `byte_o` hold their values until overwritten. No handshake: the consumer must take the data on the pulse.
- Back-to-back frames work: the next start bit may begin immediately after the stop-bit sample point. Baud tolerance is ±4%.

## Test plan
- Reset: hold `sw_rst_n`=0 for 100 ns with line idle -> all outputs 0, `busy_o`=0. After release, no pulses for 10 µs.
- Word: send 0xC9,0x03,0x4A,0xF6 at 8680/8681 ns per bit, one idle bit between bytes.
  - Required: four `byte_valid_o` pulses with those values.
  - Required: exactly one `word_valid_o`, with `word_o`=0xC9034AF6 on the 4th byte.
- Command word: send 0x53,0x54,0x4F,0x50 -> `word_o`=0x53544F50, one `word_valid_o`.
- Glitch: drive the line low for 2 µs (100 clocks).
  - Required: no `byte_valid_o` or `frame_err_o`, and `busy_o` returns to 0 within 220 clocks.
  - Then send 0x11,0x22,0x33,0x44 -> `word_o`=0x11223344.
- Framing error: send 0xAA,0xBB, then 0xA5 with its stop bit low, then raise the line.
  - Required: one `frame_err_o` and no 3rd `byte_valid_o`.
  - Then send 0xDE,0xAD,0xBE,0xEF -> `word_o`=0xDEADBEEF.
- Timeout and reset mid-frame:
  - Send 0x01,0x02 and idle 1 ms -> one `timeout_o`. Then send 0xCA,0xFE,0xBA,0xBE -> `word_o`=0xCAFEBABE.
  - Pulse `sw_rst_n` low during a byte's 4th data bit -> outputs return to reset values, and no spurious byte appears after release.
